counter_bank: RTL and testbench

COUNTER_BANK -- requirements
Module: counter_bank

---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_channel.sv | 107 ++++++++++
 rtl/counter_bank.sv | 74 +++++++
 tb/tb_counter_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter bank.
//   DefWidth    - default counter width in bits
//   DefChannels - default number of channels
//   cnt_op_e    - per-cycle channel operation after priority decode
//   chan_lsb()  - LSB position of channel ch inside a packed bus
package counter_pkg;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefChannels = 4;

    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpUp,
        OpDown
    } cnt_op_e;

    // Channel i of a packed bus occupies bits [chan_lsb(i, w) +: w].
    function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one up/down counter with terminal-count pulse.
// Optional sticky flag when COUNTER_BANK_IRQ_EN is defined.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   en, up, load     - count enable, direction (1 = up), load strobe
//   load_val, limit  - load value and terminal value
//   count, tc        - registered count and one-cycle terminal pulse
//   irq_clr          - sticky flag clear             (COUNTER_BANK_IRQ_EN only)
//   flag_next        - next value of the sticky flag (COUNTER_BANK_IRQ_EN only)
module counter_channel
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
`ifdef COUNTER_BANK_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             flag_next
`endif
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_op_e          op;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    // load beats en; direction only matters when counting.
    always_comb begin
        if (load) begin
            op = OpLoad;
        end else if (!en) begin
            op = OpHold;
        end else if (up) begin
            op = OpUp;
        end else begin
            op = OpDown;
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        unique case (op)
            OpHold: count_d = count_q;
            OpLoad: count_d = load_val;
            OpUp: begin
                // >= so a loaded value above limit terminates on its next step.
                if (count_q >= limit) begin
                    tc_d    = 1'b1;
                    count_d = SATURATE ? limit : '0;
                end else begin
                    count_d = count_q + One;
                end
            end
            OpDown: begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = SATURATE ? '0 : limit;
                end else begin
                    count_d = count_q - One;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef COUNTER_BANK_IRQ_EN
    logic flag_q;

    // A new terminal count wins over a simultaneous clear.
    always_comb begin
        flag_next = reset ? 1'b0 : (tc_d | (flag_q & ~irq_clr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_next;
        end
    end
`endif

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit up/down counters.
// Optional feature macro: COUNTER_BANK_IRQ_EN adds per-channel sticky flags,
// the irq_clr input and the irq output.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   en, up, load [CHANNELS]     - per-channel enable, direction, load strobe
//   load_val, limit [CH*WIDTH]  - packed load and terminal values
//   count [CH*WIDTH], tc [CH]   - packed registered counts, terminal pulses
//   irq_clr [CH], irq           - flag clears and registered OR of flags
module counter_bank
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned CHANNELS = DefChannels,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc
`ifdef COUNTER_BANK_IRQ_EN
    ,
    input  logic [CHANNELS-1:0]       irq_clr,
    output logic                      irq
`endif
);

`ifdef COUNTER_BANK_IRQ_EN
    logic [CHANNELS-1:0] flag_next;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .up       (up[i]),
            .load     (load[i]),
            .load_val (load_val[chan_lsb(i, WIDTH) +: WIDTH]),
            .limit    (limit[chan_lsb(i, WIDTH) +: WIDTH]),
            .count    (count[chan_lsb(i, WIDTH) +: WIDTH]),
            .tc       (tc[i])
`ifdef COUNTER_BANK_IRQ_EN
            ,
            .irq_clr  (irq_clr[i]),
            .flag_next(flag_next[i])
`endif
        );
    end

`ifdef COUNTER_BANK_IRQ_EN
    logic irq_q;

    // Registered from the next flag values so irq lines up with the flags and tc.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |flag_next;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] en, up, load;
    logic [N*W-1:0] load_val, limit;
    logic [N*W-1:0] c0, c1;
    logic [N-1:0]   t0, t1;
`ifdef COUNTER_BANK_IRQ_EN
    logic [N-1:0] irq_clr;
    logic         irq0, irq1;
`endif

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .count(c0), .tc(t0)
`ifdef COUNTER_BANK_IRQ_EN
        , .irq_clr(irq_clr), .irq(irq0)
`endif
    );

    counter_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .count(c1), .tc(t1)
`ifdef COUNTER_BANK_IRQ_EN
        , .irq_clr(irq_clr), .irq(irq1)
`endif
    );

    // Reference model: index 0 = wrapping bank, 1 = saturating bank.
    int m_cnt [2][N];
    bit m_tc  [2][N];
    bit m_flag[2][N];
    bit m_irq [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cnt(input int d, input int ch);
        return (d == 0) ? int'(c0[ch*W +: W]) : int'(c1[ch*W +: W]);
    endfunction

    function automatic int dut_tc(input int d, input int ch);
        return (d == 0) ? int'(t0[ch]) : int'(t1[ch]);
    endfunction

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            bit any = 0;
            for (int ch = 0; ch < N; ch++) begin
                int c   = m_cnt[d][ch];
                int lim = int'(limit[ch*W +: W]);
                bit t   = 0;
                bit clr = 0;
`ifdef COUNTER_BANK_IRQ_EN
                clr = irq_clr[ch];
`endif
                if (reset) begin
                    c = 0;
                end else if (load[ch]) begin
                    c = int'(load_val[ch*W +: W]);
                end else if (en[ch]) begin
                    if (up[ch]) begin
                        if (c >= lim) begin t = 1; c = (d == 1) ? lim : 0; end
                        else c = c + 1;
                    end else begin
                        if (c == 0) begin t = 1; c = (d == 1) ? 0 : lim; end
                        else c = c - 1;
                    end
                end
                m_cnt[d][ch]  = c;
                m_tc[d][ch]   = t;
                m_flag[d][ch] = reset ? 1'b0 : (t | (m_flag[d][ch] & ~clr));
                any = any | m_flag[d][ch];
            end
            m_irq[d] = reset ? 1'b0 : any;
        end
    endtask

    // One clock: advance the model, then compare every output after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < N; ch++) begin
                chk($sformatf("count[%0d][%0d]", d, ch), dut_cnt(d, ch), m_cnt[d][ch]);
                chk($sformatf("tc[%0d][%0d]", d, ch), dut_tc(d, ch), int'(m_tc[d][ch]));
            end
        end
`ifdef COUNTER_BANK_IRQ_EN
        chk("irq[0]", int'(irq0), int'(m_irq[0]));
        chk("irq[1]", int'(irq1), int'(m_irq[1]));
`endif
    endtask

    task automatic clear_inputs();
        en = '0; up = '0; load = '0; load_val = '0; limit = '0;
`ifdef COUNTER_BANK_IRQ_EN
        irq_clr = '0;
`endif
    endtask

    task automatic set_ch(input int ch, input bit e, input bit u, input bit l,
                          input int lv, input int lim);
        en[ch] = e; up[ch] = u; load[ch] = l;
        load_val[ch*W +: W] = lv[W-1:0];
        limit[ch*W +: W]    = lim[W-1:0];
    endtask

    int exp_up_wrap[6] = '{1, 2, 3, 4, 5, 0};
    int exp_up_sat [6] = '{1, 2, 3, 4, 5, 5};

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int d = 0; d < 2; d++) begin
            m_irq[d] = 0;
            for (int ch = 0; ch < N; ch++) begin
                m_cnt[d][ch] = 0; m_tc[d][ch] = 0; m_flag[d][ch] = 0;
            end
        end
        #2;
        step();
        step();
        chk("reset count", dut_cnt(0, 0), 0);
        chk("reset tc", dut_tc(1, 3), 0);
        reset = 1'b0;

        // Up count to limit 5 and wrap / saturate.
        set_ch(0, 1, 1, 0, 0, 5);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("up wrap count", dut_cnt(0, 0), exp_up_wrap[k]);
            chk("up wrap tc", dut_tc(0, 0), (k == 5) ? 1 : 0);
            chk("up sat count", dut_cnt(1, 0), exp_up_sat[k]);
        end
        clear_inputs();
        step();

        // Load 2, then count down with limit 3.
        set_ch(1, 0, 0, 1, 2, 3);
        step();
        chk("down load", dut_cnt(1, 1), 2);
        set_ch(1, 1, 0, 0, 0, 3);
        step();
        chk("down 1", dut_cnt(1, 1), 1);
        step();
        chk("down 0", dut_cnt(1, 1), 0);
        step();
        chk("down sat hold", dut_cnt(1, 1), 0);
        chk("down sat tc", dut_tc(1, 1), 1);
        chk("down wrap to limit", dut_cnt(0, 1), 3);
        chk("down wrap tc", dut_tc(0, 1), 1);
        step();
        chk("down sat hold2", dut_cnt(1, 1), 0);
        chk("down sat tc2", dut_tc(1, 1), 1);
        clear_inputs();
        step();

        // Load above limit beats en, then terminates on next step.
        set_ch(2, 1, 1, 1, 200, 100);
        step();
        chk("load over limit", dut_cnt(0, 2), 200);
        chk("load tc", dut_tc(0, 2), 0);
        set_ch(2, 1, 1, 0, 200, 100);
        step();
        chk("over limit wrap", dut_cnt(0, 2), 0);
        chk("over limit tc", dut_tc(0, 2), 1);
        chk("over limit sat", dut_cnt(1, 2), 100);
        clear_inputs();

        // Reset overrides load.
        set_ch(3, 0, 0, 1, 7, 10);
        step();
        chk("load 7", dut_cnt(0, 3), 7);
        reset = 1'b1;
        step();
        chk("reset over load", dut_cnt(0, 3), 0);
        chk("reset tc", dut_tc(0, 3), 0);
        reset = 1'b0;
        set_ch(3, 1, 1, 0, 7, 10);
        step();
        chk("after reset", dut_cnt(0, 3), 1);
        clear_inputs();

        // limit == 0: always terminal, both directions.
        set_ch(0, 0, 0, 1, 0, 0);
        step();
        set_ch(0, 1, 1, 0, 0, 0);
        step();
        chk("lim0 up", dut_cnt(0, 0), 0);
        chk("lim0 up tc", dut_tc(1, 0), 1);
        set_ch(0, 1, 0, 0, 0, 0);
        step();
        chk("lim0 down", dut_cnt(0, 0), 0);
        chk("lim0 down tc", dut_tc(0, 0), 1);
        clear_inputs();

        // All-ones limit: natural 8-bit wrap.
        set_ch(1, 0, 0, 1, 254, 255);
        step();
        set_ch(1, 1, 1, 0, 0, 255);
        step();
        chk("ff 255", dut_cnt(0, 1), 255);
        step();
        chk("ff wrap", dut_cnt(0, 1), 0);
        chk("ff wrap tc", dut_tc(0, 1), 1);
        set_ch(1, 1, 0, 0, 0, 255);
        step();
        chk("ff down wrap", dut_cnt(0, 1), 255);
        chk("ff sat down", dut_cnt(1, 1), 254);
        clear_inputs();

`ifdef COUNTER_BANK_IRQ_EN
        irq_clr = '1;
        step();
        chk("irq cleared", int'(irq0), 0);
        irq_clr = '0;
        set_ch(2, 1, 1, 0, 0, 0);
        irq_clr[2] = 1'b1;
        step();
        chk("irq set wins", int'(irq0), 1);
        en = '0;
        step();
        chk("irq clr", int'(irq0), 0);
        clear_inputs();
`endif

        // Random traffic on all channels.
        for (int ch = 0; ch < N; ch++) limit[ch*W +: W] = W'($urandom_range(0, 255));
        for (int k = 0; k < 1000; k++) begin
            en   = N'($urandom);
            up   = N'($urandom);
            load = '0;
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 15) == 0) load[ch] = 1'b1;
                load_val[ch*W +: W] = W'($urandom_range(0, 255));
                if ($urandom_range(0, 31) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       limit[ch*W +: W] = '0;
                        1:       limit[ch*W +: W] = '1;
                        default: limit[ch*W +: W] = W'($urandom_range(0, 20));
                    endcase
                end
            end
`ifdef COUNTER_BANK_IRQ_EN
            irq_clr = N'($urandom) & N'($urandom);
`endif
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
